// File: rtl/stack_op_controller_if.sv
// rtl/stack_op_controller_if.sv - opcode handshake bundle for stack_op_controller
//
// Purpose: groups the requester-to-controller opcode handshake.
// Ports (signals):
//   op_valid  requester has an opcode available
//   op_ready  controller can accept an opcode (driven by the controller)
//   op_code   4-bit opcode, sampled at handshake
//   op_data   4-bit push operand, sampled at handshake
// Modports: master = requester side, slave = controller side.
// Also provides the shared stack_register / input_selector encodings.

`ifndef STACK_MODE_IDLE
`define STACK_MODE_IDLE   3'd0
`define STACK_MODE_PUSH   3'd1
`define STACK_MODE_POP    3'd2
`define STACK_MODE_SWAP   3'd3
`define STACK_MODE_RESET  3'd4
`endif

`ifndef SELECT_INPUT_BITS
`define SELECT_INPUT_BITS 3'd0
`define SELECT_STACK_TOP0 3'd1
`define SELECT_STACK_TOP1 3'd2
`define SELECT_CALC_STORE 3'd3
`endif

interface stack_op_controller_if;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] op_code;
  logic [3:0] op_data;

  modport master (output op_valid, output op_code, output op_data, input op_ready);
  modport slave  (input op_valid, input op_code, input op_data, output op_ready);
endinterface

// File: rtl/stack_op_controller.sv
// rtl/stack_op_controller.sv - opcode sequencer driving a stack_register and input_selector
//
// Purpose: accepts one opcode at a time, sequences the stack_register mode and
// input_selector select, tracks stack occupancy and raises sticky error flags
// for ops that would overflow or underflow the stack.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave)         op_valid/op_ready/op_code/op_data handshake
//   top_word            stack top from stack_register
//   second_word         stack second word from stack_register
//   stack_mode          stack_register mode (STACK_MODE_* encodings)
//   input_select        input_selector select (SELECT_* encodings)
//   push_data           latched op_data, feeds selector inputbits
//   calc_result         AND result register, feeds selector calcstore
//   out_word            OUTL/OUTH output latch
//   depth               stack occupancy 0..STACK_DEPTH
//   err_overflow        sticky overflow flag
//   err_underflow       sticky underflow flag
//   err_clear           synchronous clear of both flags
// All outputs are registered; the mode seen in a state is loaded on the edge
// that enters it, so depth moves in the same cycle the mode is presented.

module stack_op_controller #(
  parameter int STACK_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  stack_op_controller_if.slave bus,
  input  logic [3:0]           top_word,
  input  logic [3:0]           second_word,
  output logic [2:0]           stack_mode,
  output logic [2:0]           input_select,
  output logic [3:0]           push_data,
  output logic [3:0]           calc_result,
  output logic [7:0]           out_word,
  output logic [3:0]           depth,
  output logic                 err_overflow,
  output logic                 err_underflow,
  input  logic                 err_clear
);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    IDLE   = 3'd1,
    EXEC   = 3'd2,
    AND2   = 3'd3,
    AND3   = 3'd4,
    SETTLE = 3'd5
  } state_t;

  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_POP  = 4'd2;
  localparam logic [3:0] OP_OUTL = 4'd3;
  localparam logic [3:0] OP_OUTH = 4'd4;
  localparam logic [3:0] OP_SWAP = 4'd5;
  localparam logic [3:0] OP_PEEK = 4'd6;
  localparam logic [3:0] OP_DUP  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_CLR  = 4'd9;

  localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);

  state_t     state_q, state_d;
  logic       init_seen_q, init_seen_d;
  logic [3:0] op_code_q, op_code_d;
  logic       refused_q, refused_d;   // accepted op was blocked by a guard
  logic       op_ready_q, op_ready_d;
  logic [2:0] mode_d, sel_d;
  logic [3:0] push_data_d, calc_d, depth_d;
  logic [7:0] out_d;
  logic       ovf_d, unf_d;
  logic       ovf_hit, unf_hit;

  assign bus.op_ready = op_ready_q;

  always_comb begin
    state_d     = state_q;
    init_seen_d = init_seen_q;
    op_code_d   = op_code_q;
    refused_d   = refused_q;
    op_ready_d  = 1'b0;
    mode_d      = `STACK_MODE_IDLE;
    sel_d       = `SELECT_INPUT_BITS;
    push_data_d = push_data;
    calc_d      = calc_result;
    out_d       = out_word;
    depth_d     = depth;
    ovf_hit     = 1'b0;
    unf_hit     = 1'b0;

    case (state_q)
      INIT: begin
        // Hold RESET mode for one full clocked cycle after release.
        if (init_seen_q) begin
          state_d    = IDLE;
          op_ready_d = 1'b1;
        end else begin
          init_seen_d = 1'b1;
          mode_d      = `STACK_MODE_RESET;
        end
      end

      IDLE: begin
        op_ready_d = 1'b1;
        if (bus.op_valid && op_ready_q) begin
          state_d     = EXEC;
          op_ready_d  = 1'b0;
          op_code_d   = bus.op_code;
          push_data_d = bus.op_data;

          case (bus.op_code)
            OP_PUSH:                 ovf_hit = (depth == DEPTH_MAX);
            OP_POP, OP_OUTL, OP_OUTH: unf_hit = (depth == 4'd0);
            OP_SWAP, OP_AND:         unf_hit = (depth < 4'd2);
            OP_PEEK: begin
              ovf_hit = (depth == DEPTH_MAX);
              unf_hit = (depth < 4'd2);
            end
            OP_DUP: begin
              ovf_hit = (depth == DEPTH_MAX);
              unf_hit = (depth == 4'd0);
            end
            default: ;
          endcase
          // Overflow wins so a refused op only ever raises one flag.
          unf_hit   = unf_hit && !ovf_hit;
          refused_d = ovf_hit || unf_hit;

          if (!(ovf_hit || unf_hit)) begin
            case (bus.op_code)
              OP_PUSH: begin
                mode_d  = `STACK_MODE_PUSH;
                depth_d = depth + 4'd1;
              end
              OP_POP: begin
                mode_d  = `STACK_MODE_POP;
                depth_d = depth - 4'd1;
              end
              OP_OUTL: out_d = {out_word[7:4], top_word};
              OP_OUTH: out_d = {top_word, out_word[3:0]};
              OP_SWAP: mode_d = `STACK_MODE_SWAP;
              OP_PEEK: begin
                mode_d  = `STACK_MODE_PUSH;
                sel_d   = `SELECT_STACK_TOP1;
                depth_d = depth + 4'd1;
              end
              OP_DUP: begin
                mode_d  = `STACK_MODE_PUSH;
                sel_d   = `SELECT_STACK_TOP0;
                depth_d = depth + 4'd1;
              end
              OP_AND: begin
                // Operands are still in place until the first POP lands.
                calc_d  = top_word & second_word;
                mode_d  = `STACK_MODE_POP;
                depth_d = depth - 4'd1;
              end
              OP_CLR: begin
                mode_d  = `STACK_MODE_RESET;
                depth_d = 4'd0;
              end
              default: ;
            endcase
          end
        end
      end

      EXEC: begin
        if (op_code_q == OP_AND && !refused_q) begin
          state_d = AND2;
          mode_d  = `STACK_MODE_POP;
          depth_d = depth - 4'd1;
        end else begin
          state_d = SETTLE;
        end
      end

      AND2: begin
        state_d = AND3;
        mode_d  = `STACK_MODE_PUSH;
        sel_d   = `SELECT_CALC_STORE;
        depth_d = depth + 4'd1;
      end

      AND3: state_d = SETTLE;

      SETTLE: begin
        state_d    = IDLE;
        op_ready_d = 1'b1;
      end

      default: state_d = INIT;
    endcase

    // A new error on the same edge as err_clear takes priority.
    ovf_d = (err_overflow  && !err_clear) || ovf_hit;
    unf_d = (err_underflow && !err_clear) || unf_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT;
      init_seen_q   <= 1'b0;
      op_code_q     <= 4'd0;
      refused_q     <= 1'b0;
      op_ready_q    <= 1'b0;
      stack_mode    <= `STACK_MODE_RESET;
      input_select  <= `SELECT_INPUT_BITS;
      push_data     <= 4'd0;
      calc_result   <= 4'd0;
      out_word      <= 8'd0;
      depth         <= 4'd0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_seen_q   <= init_seen_d;
      op_code_q     <= op_code_d;
      refused_q     <= refused_d;
      op_ready_q    <= op_ready_d;
      stack_mode    <= mode_d;
      input_select  <= sel_d;
      push_data     <= push_data_d;
      calc_result   <= calc_d;
      out_word      <= out_d;
      depth         <= depth_d;
      err_overflow  <= ovf_d;
      err_underflow <= unf_d;
    end
  end

endmodule

// File: tb/tb_stack_op_controller.sv
// tb/tb_stack_op_controller.sv - directed self-checking bench for stack_op_controller

`ifndef STACK_MODE_IDLE
`define STACK_MODE_IDLE   3'd0
`define STACK_MODE_PUSH   3'd1
`define STACK_MODE_POP    3'd2
`define STACK_MODE_SWAP   3'd3
`define STACK_MODE_RESET  3'd4
`endif

`ifndef SELECT_INPUT_BITS
`define SELECT_INPUT_BITS 3'd0
`define SELECT_STACK_TOP0 3'd1
`define SELECT_STACK_TOP1 3'd2
`define SELECT_CALC_STORE 3'd3
`endif

module tb_stack_op_controller;

  logic       clk;
  logic       rst_n;
  logic [3:0] top_word;
  logic [3:0] second_word;
  logic [2:0] stack_mode;
  logic [2:0] input_select;
  logic [3:0] push_data;
  logic [3:0] calc_result;
  logic [7:0] out_word;
  logic [3:0] depth;
  logic       err_overflow;
  logic       err_underflow;
  logic       err_clear;

  int n_checks = 0;
  int n_pass   = 0;

  stack_op_controller_if ifc ();

  stack_op_controller #(.STACK_DEPTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (ifc),
    .top_word     (top_word),
    .second_word  (second_word),
    .stack_mode   (stack_mode),
    .input_select (input_select),
    .push_data    (push_data),
    .calc_result  (calc_result),
    .out_word     (out_word),
    .depth        (depth),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow),
    .err_clear    (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ifc.op_ready && n < 20) begin
      step();
      n++;
    end
    if (!ifc.op_ready) check({tag, "_ready_timeout"}, 8'd0, 8'd1);
  endtask

  // Returns #1 after the accept edge, so EXEC-cycle outputs are visible.
  task automatic send(input logic [3:0] code, input logic [3:0] data, input logic clr);
    wait_ready("send");
    ifc.op_valid = 1'b1;
    ifc.op_code  = code;
    ifc.op_data  = data;
    err_clear    = clr;
    step();
    ifc.op_valid = 1'b0;
    err_clear    = 1'b0;
  endtask

  task automatic clear_errors();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
  endtask

  initial begin
    ifc.op_valid = 1'b0;
    ifc.op_code  = 4'd0;
    ifc.op_data  = 4'd0;
    top_word     = 4'd0;
    second_word  = 4'd0;
    err_clear    = 1'b0;
    rst_n        = 1'b1;
    #1 rst_n     = 1'b0;
    #2;
    check("rst_mode",  stack_mode, `STACK_MODE_RESET);
    check("rst_sel",   input_select, `SELECT_INPUT_BITS);
    check("rst_ready", ifc.op_ready, 1'b0);
    check("rst_depth", depth, 4'd0);
    check("rst_out",   out_word, 8'h00);
    check("rst_flags", {err_overflow, err_underflow}, 2'b00);

    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("init_mode",  stack_mode, `STACK_MODE_RESET);
    check("init_ready", ifc.op_ready, 1'b0);
    step();
    check("idle_mode",  stack_mode, `STACK_MODE_IDLE);
    check("idle_ready", ifc.op_ready, 1'b1);

    // PUSH 0xA then PUSH 0x3, with ready timing.
    send(4'd1, 4'hA, 1'b0);
    check("push1_mode",  stack_mode, `STACK_MODE_PUSH);
    check("push1_sel",   input_select, `SELECT_INPUT_BITS);
    check("push1_data",  push_data, 4'hA);
    check("push1_depth", depth, 4'd1);
    check("push1_busy",  ifc.op_ready, 1'b0);
    step();
    check("push1_settle", stack_mode, `STACK_MODE_IDLE);
    check("push1_busy2",  ifc.op_ready, 1'b0);
    step();
    check("push1_ready",  ifc.op_ready, 1'b1);
    send(4'd1, 4'h3, 1'b0);
    check("push2_mode",  stack_mode, `STACK_MODE_PUSH);
    check("push2_depth", depth, 4'd2);
    step();
    step();
    check("push2_ready", ifc.op_ready, 1'b1);

    // AND with 3 on top of A -> 2, then OUTL.
    top_word    = 4'h3;
    second_word = 4'hA;
    send(4'd8, 4'h0, 1'b0);
    check("and_calc",  calc_result, 4'h2);
    check("and_m1",    stack_mode, `STACK_MODE_POP);
    check("and_d1",    depth, 4'd1);
    step();
    check("and_m2",    stack_mode, `STACK_MODE_POP);
    check("and_d2",    depth, 4'd0);
    step();
    check("and_m3",    stack_mode, `STACK_MODE_PUSH);
    check("and_sel3",  input_select, `SELECT_CALC_STORE);
    check("and_d3",    depth, 4'd1);
    step();
    check("and_settle", stack_mode, `STACK_MODE_IDLE);
    top_word    = 4'h2;
    second_word = 4'h0;
    send(4'd3, 4'h0, 1'b0);
    check("outl_word",  out_word, 8'h02);
    check("outl_mode",  stack_mode, `STACK_MODE_IDLE);
    check("outl_depth", depth, 4'd1);

    // Depth 3, then CLR, then opcode 0xC as NOOP.
    send(4'd1, 4'h5, 1'b0);
    send(4'd1, 4'h6, 1'b0);
    check("pre_clr_depth", depth, 4'd3);
    send(4'd9, 4'h0, 1'b0);
    check("clr_mode",  stack_mode, `STACK_MODE_RESET);
    check("clr_depth", depth, 4'd0);
    step();
    check("clr_settle", stack_mode, `STACK_MODE_IDLE);
    send(4'hC, 4'h0, 1'b0);
    check("noop_mode",  stack_mode, `STACK_MODE_IDLE);
    check("noop_depth", depth, 4'd0);
    wait_ready("noop");
    check("noop_flags", {err_overflow, err_underflow}, 2'b00);

    // POP at empty -> underflow, cleared by err_clear.
    send(4'd2, 4'h0, 1'b0);
    check("upop_mode",  stack_mode, `STACK_MODE_IDLE);
    check("upop_depth", depth, 4'd0);
    wait_ready("upop");
    check("upop_flags", {err_overflow, err_underflow}, 2'b01);
    clear_errors();
    check("upop_clear", err_underflow, 1'b0);

    // Fill to 8, overflow, set beats clear on the same edge.
    for (int i = 0; i < 8; i++) send(4'd1, 4'(i), 1'b0);
    check("full_depth", depth, 4'd8);
    send(4'd1, 4'hF, 1'b0);
    check("ovf_mode",  stack_mode, `STACK_MODE_IDLE);
    check("ovf_depth", depth, 4'd8);
    check("ovf_flag",  err_overflow, 1'b1);
    send(4'd1, 4'hE, 1'b1);
    check("ovf_set_wins", err_overflow, 1'b1);
    wait_ready("ovf");
    clear_errors();
    check("ovf_clear", err_overflow, 1'b0);

    // PEEK at full: overflow only.
    send(4'd6, 4'h0, 1'b0);
    check("peek_full_flags", {err_overflow, err_underflow}, 2'b10);
    check("peek_full_depth", depth, 4'd8);

    // Reset asserted during AND2.
    send(4'd8, 4'h0, 1'b0);
    step();
    check("and2_mode",  stack_mode, `STACK_MODE_POP);
    check("and2_depth", depth, 4'd6);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mode",  stack_mode, `STACK_MODE_RESET);
    check("abort_depth", depth, 4'd0);
    check("abort_ready", ifc.op_ready, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("reinit_mode",  stack_mode, `STACK_MODE_RESET);
    check("reinit_ready", ifc.op_ready, 1'b0);
    step();
    check("reidle_ready", ifc.op_ready, 1'b1);

    // DUP at empty -> underflow, no push.
    send(4'd7, 4'h0, 1'b0);
    check("dup_empty_mode",  stack_mode, `STACK_MODE_IDLE);
    check("dup_empty_flags", {err_overflow, err_underflow}, 2'b01);
    wait_ready("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
